// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant owner codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between core and host requests; ARB_ROUND_ROBIN_EN selects alternating grants.
// Latency: purely combinational.
// Backpressure: none; the caller only consumes the result while idle.
module mem_arb_select (
  input  logic       i_core_req,
  input  logic       i_ext_req,
  input  logic       i_last_ext,
  output logic       o_gnt_vld,
  output logic [1:0] o_gnt_owner
);
  import mem_arb_pkg::*;

  assign o_gnt_vld = i_core_req | i_ext_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention grant whoever was not served last; otherwise whoever asks.
  always_comb begin
    o_gnt_owner = OWN_NONE;
    if (i_core_req && i_ext_req) begin
      o_gnt_owner = i_last_ext ? OWN_CORE : OWN_EXT;
    end else if (i_core_req) begin
      o_gnt_owner = OWN_CORE;
    end else if (i_ext_req) begin
      o_gnt_owner = OWN_EXT;
    end
  end
`else
  // History is irrelevant with fixed priority.
  logic w_unused_last_ext;
  assign w_unused_last_ext = i_last_ext;

  // Fixed priority: the core always wins a contention.
  always_comb begin
    o_gnt_owner = OWN_NONE;
    if (i_core_req) begin
      o_gnt_owner = OWN_CORE;
    end else if (i_ext_req) begin
      o_gnt_owner = OWN_EXT;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between core and host; IDLE/XFER/DONE FSM with bus timeout (macro ARB_ROUND_ROBIN_EN).
// Latency: 3 cycles minimum per transfer, +1 per memory wait cycle, error completion after TIMEOUT+1 XFER cycles.
// Backpressure: requesters hold req/payload until their one-cycle ready pulse; the loser waits for the next IDLE.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [WIDTH-1:0]  core_wdata,
  output logic [WIDTH-1:0]  core_rdata,
  output logic              core_ready,
  output logic              core_err,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_wdata,
  output logic [WIDTH-1:0]  ext_rdata,
  output logic              ext_ready,
  output logic              ext_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner
);
  import mem_arb_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic [WIDTH-1:0]  r_core_rdata;
  logic              r_core_ready;
  logic              r_core_err;
  logic [WIDTH-1:0]  r_ext_rdata;
  logic              r_ext_ready;
  logic              r_ext_err;

  logic              w_gnt_vld;
  logic [1:0]        w_gnt_owner;
  logic              w_gnt_core;
  logic              w_last_ext;
  logic              w_own_core;
  logic [WIDTH-1:0]  w_rd_dat;

  mem_arb_select u_select (
    .i_core_req  (core_req),
    .i_ext_req   (ext_req),
    .i_last_ext  (w_last_ext),
    .o_gnt_vld   (w_gnt_vld),
    .o_gnt_owner (w_gnt_owner)
  );

  assign w_gnt_core = (w_gnt_owner == OWN_CORE);
  assign w_own_core = (r_owner == OWN_CORE);
  // Writes complete with zero read data.
  assign w_rd_dat   = r_mem_we ? '0 : mem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_ext;

  // Remember who was granted last; starting at ext lets the core win the first contention.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last_ext <= 1'b1;
    end else if (r_state == IDLE && w_gnt_vld) begin
      r_last_ext <= (w_gnt_owner == OWN_EXT);
    end
  end

  assign w_last_ext = r_last_ext;
`else
  assign w_last_ext = 1'b1;
`endif

  // Transfer sequencer: grant in IDLE, hold the memory strobe in XFER, pulse ready in DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_owner      <= OWN_NONE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_core_ready <= 1'b0;
      r_core_err   <= 1'b0;
      r_ext_rdata  <= '0;
      r_ext_ready  <= 1'b0;
      r_ext_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_owner     <= w_gnt_owner;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_gnt_core ? core_we    : ext_we;
            r_mem_addr  <= w_gnt_core ? core_addr  : ext_addr;
            r_mem_wdata <= w_gnt_core ? core_wdata : ext_wdata;
            r_cnt       <= '0;
            r_state     <= XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            if (w_own_core) begin
              r_core_ready <= 1'b1;
              r_core_rdata <= w_rd_dat;
              r_core_err   <= 1'b0;
            end else begin
              r_ext_ready  <= 1'b1;
              r_ext_rdata  <= w_rd_dat;
              r_ext_err    <= 1'b0;
            end
            r_state <= DONE;
          end else if (r_cnt == CNT_TO) begin
            // Hung access: complete with an error and no data.
            r_mem_req <= 1'b0;
            if (w_own_core) begin
              r_core_ready <= 1'b1;
              r_core_rdata <= '0;
              r_core_err   <= 1'b1;
            end else begin
              r_ext_ready  <= 1'b1;
              r_ext_rdata  <= '0;
              r_ext_err    <= 1'b1;
            end
            r_state <= DONE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_core_ready <= 1'b0;
          r_core_rdata <= '0;
          r_core_err   <= 1'b0;
          r_ext_ready  <= 1'b0;
          r_ext_rdata  <= '0;
          r_ext_err    <= 1'b0;
          r_owner      <= OWN_NONE;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign owner      = r_owner;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rdata = r_core_rdata;
  assign core_ready = r_core_ready;
  assign core_err   = r_core_err;
  assign ext_rdata  = r_ext_rdata;
  assign ext_ready  = r_ext_ready;
  assign ext_err    = r_ext_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): reads, waits, timeout, stability, contention, reset.
// Latency: checks the 3-cycle minimum transfer and per-wait-cycle stretch.
// Backpressure: requesters hold req until their ready pulse.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        core_req, core_we, ext_req, ext_we, mem_ready;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata, mem_rdata;
  logic [31:0] core_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        core_ready, core_err, ext_ready, ext_err, mem_req, mem_we;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready), .core_err(core_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ready(ext_ready), .ext_err(ext_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int rdy_seen;
    logic [1:0] exp_own [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{2'd1, 2'd2, 2'd1, 2'd2};
`else
    exp_own = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
    RST = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_ext_ready", 32'(ext_ready), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    RST = 1'b1;
    tick();

    // Core read, zero wait
    core_req = 1; core_we = 0; core_addr = 32'h100;
    mem_rdata = 32'hDEADBEEF; mem_ready = 1;
    tick();
    chk("cr_mem_req", 32'(mem_req), 32'd1);
    chk("cr_owner", 32'(owner), 32'd1);
    chk("cr_mem_addr", mem_addr, 32'h100);
    chk("cr_mem_we", 32'(mem_we), 32'd0);
    chk("cr_early_ready", 32'(core_ready), 32'd0);
    tick();
    chk("cr_ready", 32'(core_ready), 32'd1);
    chk("cr_rdata", core_rdata, 32'hDEADBEEF);
    chk("cr_err", 32'(core_err), 32'd0);
    chk("cr_mem_req_done", 32'(mem_req), 32'd0);
    chk("cr_ext_ready", 32'(ext_ready), 32'd0);
    core_req = 0; mem_ready = 0;
    tick();
    chk("cr_ready_clr", 32'(core_ready), 32'd0);
    chk("cr_owner_clr", 32'(owner), 32'd0);

    // Ext write with 3 wait cycles
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h55;
    mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ew_mem_req", 32'(mem_req), 32'd1);
      chk("ew_mem_we", 32'(mem_we), 32'd1);
      chk("ew_mem_addr", mem_addr, 32'h20);
      chk("ew_mem_wdata", mem_wdata, 32'h55);
      chk("ew_owner", 32'(owner), 32'd2);
      chk("ew_ready_wait", 32'(ext_ready), 32'd0);
    end
    mem_ready = 1;
    tick();
    chk("ew_ready", 32'(ext_ready), 32'd1);
    chk("ew_rdata", ext_rdata, 32'd0);
    chk("ew_err", 32'(ext_err), 32'd0);
    chk("ew_core_ready", 32'(core_ready), 32'd0);
    ext_req = 0; ext_we = 0; mem_ready = 0;
    tick();

    // Timeout: mem_ready stuck low
    core_req = 1; core_we = 0; core_addr = 32'h200; mem_rdata = 32'h12345678;
    n = 0;
    tick();
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    chk("to_mem_req_cycles", 32'(n), 32'd5);
    chk("to_ready", 32'(core_ready), 32'd1);
    chk("to_err", 32'(core_err), 32'd1);
    chk("to_rdata", core_rdata, 32'd0);
    core_req = 0;
    tick();
    chk("to_err_clr", 32'(core_err), 32'd0);

    // Stability: ext toggles while core is served
    core_req = 1; core_we = 0; core_addr = 32'h300; mem_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_mem_addr", mem_addr, 32'h300);
      chk("st_owner", 32'(owner), 32'd1);
      chk("st_ext_ready", 32'(ext_ready), 32'd0);
      ext_req = ~ext_req;
      ext_addr = 32'h40 + 32'(i);
    end
    mem_ready = 1;
    ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    tick();
    chk("st_core_ready", 32'(core_ready), 32'd1);
    chk("st_core_rdata", core_rdata, 32'hA5A5A5A5);
    chk("st_ext_ready_done", 32'(ext_ready), 32'd0);
    chk("st_ext_rdata_done", ext_rdata, 32'd0);
    core_req = 0;
    mem_rdata = 32'h0BADF00D;
    tick();
    tick();
    chk("st_ext_owner", 32'(owner), 32'd2);
    chk("st_ext_addr", mem_addr, 32'h44);
    tick();
    chk("st_ext_ready_gnt", 32'(ext_ready), 32'd1);
    chk("st_ext_rdata_gnt", ext_rdata, 32'h0BADF00D);
    ext_req = 0;
    tick();

    // Contention: both request continuously, zero-wait memory
    core_req = 1; core_addr = 32'h500; ext_req = 1; ext_addr = 32'h600;
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ct_owner", 32'(owner), 32'(exp_own[i]));
      chk("ct_mem_req", 32'(mem_req), 32'd1);
      tick();
      chk("ct_core_ready", 32'(core_ready), (exp_own[i] == 2'd1) ? 32'd1 : 32'd0);
      chk("ct_ext_ready", 32'(ext_ready), (exp_own[i] == 2'd2) ? 32'd1 : 32'd0);
      if (i == 3) begin
        core_req = 0; ext_req = 0;
      end
      tick();
      chk("ct_idle_mem_req", 32'(mem_req), 32'd0);
    end

    // Reset in the middle of a transfer
    ext_req = 1; ext_addr = 32'h700; mem_ready = 0;
    tick();
    tick();
    chk("rx_pre_mem_req", 32'(mem_req), 32'd1);
    RST = 1'b0;
    #1;
    chk("rx_mem_req", 32'(mem_req), 32'd0);
    chk("rx_owner", 32'(owner), 32'd0);
    chk("rx_core_ready", 32'(core_ready), 32'd0);
    chk("rx_ext_ready", 32'(ext_ready), 32'd0);
    ext_req = 0;
    tick();
    RST = 1'b1;
    rdy_seen = 0;
    mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (core_ready || ext_ready || mem_req) rdy_seen++;
    end
    chk("rx_no_completion", 32'(rdy_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
